// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver.
// Holds the glyph table (segment order {a,b,c,d,e,f,g}) and the per-slot FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    localparam logic [6:0] SEG_ALL_ON = 7'b1111111;
    localparam logic [6:0] SEG_OFF    = 7'b0000000;

    typedef enum logic {
        S_GUARD,
        S_DRIVE
    } state_e;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus: digit/dp/blank load inputs and pin outputs.
// master = datapath/driver side, slave = seg7_scan_driver.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic                    lz_suppress;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    slot_o;

    modport master (
        output load, digits_i, dp_i, blank_i, lz_suppress,
        input  seg_o, dp_o, an_o, slot_o
    );

    modport slave (
        input  load, digits_i, dp_i, blank_i, lz_suppress,
        output seg_o, dp_o, an_o, slot_o
    );
endinterface

// File: rtl/seg7_glyph.sv
// Nibble to 7-segment glyph, combinational.
// nib_i: 4-bit code; seg_o: {a..g} active-high; codes A-F are hex glyphs or all-on per HEX_MODE.
module seg7_glyph
    import seg7_pkg::*;
#(
    parameter int HEX_MODE = 0
) (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    localparam bit HEX = (HEX_MODE != 0);

    always_comb begin
        seg_o = SEG_ALL_ON;
        unique case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = HEX ? SEG_A : SEG_ALL_ON;
            4'hB: seg_o = HEX ? SEG_B : SEG_ALL_ON;
            4'hC: seg_o = HEX ? SEG_C : SEG_ALL_ON;
            4'hD: seg_o = HEX ? SEG_D : SEG_ALL_ON;
            4'hE: seg_o = HEX ? SEG_E : SEG_ALL_ON;
            4'hF: seg_o = HEX ? SEG_F : SEG_ALL_ON;
        endcase
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with shadow regs, guard blanking and LZ suppression.
// Ports: clk, rst (async high); bus.slave carries load/digits/dp/blank/lz inputs and seg/dp/an/slot pins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50000,
    parameter int GUARD_CYC  = 2,
    parameter int HEX_MODE   = 0,
    parameter int ACTIVE_LOW = 0
) (
    input logic               clk,
    input logic               rst,
    seg7_scan_driver_if.slave bus
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam state_e ST_START = (GUARD_CYC == 0) ? S_DRIVE : S_GUARD;
    localparam bit INV = (ACTIVE_LOW != 0);

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q, blank_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    state_e                  state_q, state_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q_o, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    slot_q, slot_d;

    logic [3:0]              nib;
    logic [6:0]              glyph;
    logic [NUM_DIGITS-1:0]   zero_up;
    logic                    guard_next;
    logic                    dark;

    // Shadow: all three fields move together so a digit never shows mixed data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits_q <= '0;
            dp_q     <= '0;
            blank_q  <= '0;
        end else if (bus.load) begin
            digits_q <= bus.digits_i;
            dp_q     <= bus.dp_i;
            blank_q  <= bus.blank_i;
        end
    end

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    if (GUARD_CYC == 0) begin : g_noguard
        assign guard_next = 1'b0;
    end else begin : g_guard
        localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD_CYC);
        assign guard_next = (cnt_d < GUARD_V);
    end

    // zero_up[k]: digits k..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_up = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            zero_up[k] = ((digits_q >> (4 * k)) == '0);
        end
    end

    assign nib = digits_q[{idx_q, 2'b00} +: 4];

    seg7_glyph #(
        .HEX_MODE (HEX_MODE)
    ) u_glyph (
        .nib_i (nib),
        .seg_o (glyph)
    );

    assign dark = blank_q[idx_q]
                | (bus.lz_suppress & zero_up[idx_q] & (idx_q != '0));

    always_comb begin
        state_d = guard_next ? S_GUARD : S_DRIVE;
        seg_d   = SEG_OFF;
        dp_d    = 1'b0;
        an_d    = '0;
        slot_d  = (cnt_q == '0);
        unique case (state_q)
            S_GUARD: begin
            end
            S_DRIVE: begin
                an_d[idx_q] = 1'b1;
                if (!dark) begin
                    seg_d = glyph;
                    dp_d  = dp_q[idx_q];
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_START;
            seg_q   <= SEG_OFF;
            dp_q_o  <= 1'b0;
            an_q    <= '0;
            slot_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            state_q <= state_d;
            seg_q   <= seg_d;
            dp_q_o  <= dp_d;
            an_q    <= an_d;
            slot_q  <= slot_d;
        end
    end

    // Pin polarity sits after the registers so the pins stay glitch-free.
    assign bus.seg_o  = INV ? ~seg_q  : seg_q;
    assign bus.dp_o   = INV ? ~dp_q_o : dp_q_o;
    assign bus.an_o   = INV ? ~an_q   : an_q;
    assign bus.slot_o = slot_q;
endmodule
